multdiv_seq_32: RTL and testbench

Sequential 32-bit signed multiply/divide unit. Sits in the execute stage beside the ALU and barrel shifters, and takes the same operand buses. Multiply is radix-2 Booth: an add/subtract, then a 1-bit arithmetic right shift of the product register, each cycle. Divide is non-restoring on operand magnitudes. The pipeline stalls on busy and collects the result on data_resultRDY.

---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/multdiv_counter.sv | 31 +++
 rtl/multdiv_seq_32.sv | 163 ++++++++++++++++
 tb/tb_multdiv_seq_32.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Contents: FSM state enum, iteration count, signed corner-case operand
// constants and a 32-bit magnitude helper used by the divider.
package multdiv_pkg;

    localparam int unsigned ITER = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        DFIX,
        DONE
    } state_t;

    // Magnitude of a two's complement word; INT_MIN maps to 0x80000000 unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? 32'(-x) : x;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for multdiv_seq_32.
// Ports: clock, reset_n (async active-low), clear (sync, wins over en),
//        en (count up), done_c (combinational, high when count == ITER-1).
module multdiv_counter #(
    parameter int unsigned ITER = multdiv_pkg::ITER
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic done_c
);

    localparam int unsigned CW = 6;

    logic [CW-1:0] count;

    // Counter register: clear on every accepted start, advance per iteration.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign done_c = (count == CW'(ITER - 1));

endmodule

// File: rtl/multdiv_seq_32.sv
// Sequential 32-bit signed multiply (radix-2 Booth) / divide (non-restoring
// on magnitudes) unit for the execute stage.
// Ports: clock, reset_n (async active-low), data_operandA/B (signed operands),
//        ctrl_MULT/ctrl_DIV (start requests, MULT wins), data_result,
//        data_exception (overflow / divide-by-zero), data_resultRDY (one-cycle
//        completion pulse), busy (operation in flight).
module multdiv_seq_32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = multdiv_pkg::ITER
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    import multdiv_pkg::*;

    // Product register: 33-bit high part (headroom for -INT_MIN), low word, q-1.
    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam int unsigned RW = WIDTH + 1;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             rdy_nxt;
    logic             start_ok_c;
    logic             start_mult_c;
    logic             start_div_c;
    logic             div0_c;
    logic             cnt_done_c;

    logic [RW-1:0]    opnd;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_step_c;
    logic [RW-1:0]    hi_c;
    logic [RW-1:0]    hi_new_c;
    logic [WIDTH:0]   prod_top_c;
    logic             mult_ovf_c;
    logic [RW-1:0]    rem;
    logic [RW-1:0]    rem_shift_c;
    logic [RW-1:0]    rem_step_c;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] quo_step_c;
    logic             neg_q;
    logic             div_ovf;

    multdiv_counter #(.ITER(ITER)) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_mult_c | start_div_c),
        .en      ((state == MULT) || (state == DIV)),
        .done_c  (cnt_done_c)
    );

    // State and status-output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_nxt;
            busy           <= busy_nxt;
            data_resultRDY <= rdy_nxt;
        end
    end

    // Next-state logic; starts are only honoured in IDLE or DONE.
    always_comb begin
        state_nxt    = state;
        start_ok_c   = (state == IDLE) || (state == DONE);
        start_mult_c = start_ok_c & ctrl_MULT;
        start_div_c  = start_ok_c & ctrl_DIV & ~ctrl_MULT;
        div0_c       = start_div_c & (data_operandB == '0);
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start_mult_c)     state_nxt = MULT;
                else if (div0_c)      state_nxt = DONE;
                else if (start_div_c) state_nxt = DIV;
            end
            MULT:    if (cnt_done_c) state_nxt = DONE;
            DIV:     if (cnt_done_c) state_nxt = DFIX;
            DFIX:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == MULT) || (state_nxt == DIV) || (state_nxt == DFIX);
        rdy_nxt  = (state_nxt == DONE);
    end

    // One Booth step and one non-restoring division step.
    always_comb begin
        hi_c     = prod[PW-1:WIDTH+1];
        hi_new_c = hi_c;
        case ({prod[1], prod[0]})
            2'b01:   hi_new_c = hi_c + opnd;
            2'b10:   hi_new_c = hi_c - opnd;
            default: hi_new_c = hi_c;
        endcase
        prod_step_c = {hi_new_c[RW-1], hi_new_c, prod[WIDTH:1]};
        // Product bits [63:31] must be a pure sign extension to fit in 32 bits.
        prod_top_c  = prod_step_c[2*WIDTH:WIDTH];
        mult_ovf_c  = ~((&prod_top_c) | ~(|prod_top_c));

        rem_shift_c = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_step_c  = rem[RW-1] ? (rem_shift_c + opnd) : (rem_shift_c - opnd);
        quo_step_c  = {quo[WIDTH-2:0], ~rem_step_c[RW-1]};
    end

    // Datapath and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opnd           <= '0;
            prod           <= '0;
            rem            <= '0;
            quo            <= '0;
            neg_q          <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start_mult_c) begin
            opnd <= {data_operandA[WIDTH-1], data_operandA};
            prod <= {RW'(0), data_operandB, 1'b0};
        end else if (start_div_c) begin
            opnd    <= {1'b0, abs32(data_operandB)};
            rem     <= '0;
            quo     <= abs32(data_operandA);
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_ovf <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
            if (div0_c) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end
        end else begin
            case (state)
                MULT: begin
                    prod <= prod_step_c;
                    if (cnt_done_c) begin
                        data_result    <= prod_step_c[WIDTH:1];
                        data_exception <= mult_ovf_c;
                    end
                end
                DIV: begin
                    rem <= rem_step_c;
                    quo <= quo_step_c;
                end
                DFIX: begin
                    data_result    <= neg_q ? WIDTH'(-quo) : quo;
                    data_exception <= div_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq_32.sv
// Self-checking bench for multdiv_seq_32: directed corner cases plus random
// multiply/divide operations compared against a plain-arithmetic model.
module tb_multdiv_seq_32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    always #5 clock = ~clock;

    multdiv_seq_32 dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic with the unit's exception rules and latencies.
    function automatic void ref_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     ia;
        int     ib;
        ia = $signed(a);
        ib = $signed(b);
        if (m) begin
            p   = longint'(ia) * longint'(ib);
            r   = p[31:0];
            e   = (p != longint'($signed(r)));
            lat = 33;
        end else if (ib == 0) begin
            r   = 32'h0;
            e   = 1'b1;
            lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = 32'h8000_0000;
            e   = 1'b1;
            lat = 34;
        end else begin
            r   = 32'(ia / ib);
            e   = 1'b0;
            lat = 34;
        end
    endfunction

    // Called at a negedge; start edge is the next posedge (cycle 0).
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input logic inj_m, input logic inj_d);
        logic [31:0] er;
        logic        ee;
        int          lat;
        int          got;
        int          busy_err;
        ref_op(m, a, b, er, ee, lat);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        got      = 0;
        busy_err = 0;
        for (int cyc = 1; cyc <= lat + 4 && got == 0; cyc++) begin
            @(negedge clock);
            ctrl_MULT     = (cyc == inj_cyc) && inj_m;
            ctrl_DIV      = (cyc == inj_cyc) && inj_d;
            data_operandA = $urandom;
            data_operandB = $urandom;
            if (busy !== (cyc < lat)) busy_err++;
            if (data_resultRDY === 1'b1) got = cyc;
        end
        chk({tag, ".rdy_cycle"}, 64'(got), 64'(lat));
        chk({tag, ".result"}, 64'(data_result), 64'(er));
        chk({tag, ".exception"}, 64'(data_exception), 64'(ee));
        chk({tag, ".busy_profile"}, 64'(busy_err), 64'd0);
        last_res = er;
        last_exc = ee;
    endtask

    // One cycle after a completion: pulse gone, result held.
    task automatic idle_check(input string tag);
        @(negedge clock);
        chk({tag, ".rdy_low"}, 64'(data_resultRDY), 64'd0);
        chk({tag, ".busy_low"}, 64'(busy), 64'd0);
        chk({tag, ".result_held"}, 64'(data_result), 64'(last_res));
        chk({tag, ".exc_held"}, 64'(data_exception), 64'(last_exc));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        seen;

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset.result", 64'(data_result), 64'd0);
        chk("reset.exception", 64'(data_exception), 64'd0);
        chk("reset.rdy", 64'(data_resultRDY), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op("mult_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, 1'b0);
        idle_check("mult_7x-3");
        run_op("mult_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, 1'b0);
        idle_check("mult_ovf");
        run_op("mult_intmin", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b0);
        idle_check("mult_intmin");
        run_op("div_-100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b0, 1'b0);
        idle_check("div_-100/7");
        run_op("div_intmin/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        idle_check("div_intmin/-1");
        run_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 0, 1'b0, 1'b0);
        idle_check("div_by_zero");
        run_op("both_ctrl", 1'b1, 1'b1, 32'd6, 32'd3, 0, 1'b0, 1'b0);
        idle_check("both_ctrl");
        run_op("mult_div_ignored", 1'b1, 1'b0, 32'd7, 32'd3, 10, 1'b0, 1'b1);
        run_op("back_to_back", 1'b1, 1'b0, 32'd9, 32'hFFFF_FFF7, 0, 1'b0, 1'b0);
        idle_check("back_to_back");

        // Asynchronous reset in the middle of a multiply.
        data_operandA = 32'd7;
        data_operandB = 32'd3;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("midreset.result", 64'(data_result), 64'd0);
        chk("midreset.exception", 64'(data_exception), 64'd0);
        chk("midreset.rdy", 64'(data_resultRDY), 64'd0);
        chk("midreset.busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen    = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("midreset.no_pulse", 64'(seen), 64'd0);
        run_op("after_reset_2x2", 1'b1, 1'b0, 32'd2, 32'd2, 0, 1'b0, 1'b0);
        idle_check("after_reset_2x2");

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) begin
                a = 32'($signed(32'($urandom_range(0, 131070))) - 65535);
                b = 32'($signed(32'($urandom_range(0, 131070))) - 65535);
            end
            run_op("rand_mult", 1'b1, 1'b0, a, b, 0, 1'b0, 1'b0);
            @(negedge clock);
        end

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = 32'($signed(32'($urandom_range(0, 20))) - 10);
            run_op("rand_div", 1'b0, 1'b1, a, b, 0, 1'b0, 1'b0);
            idle_check("rand_div");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
